// File: rtl/note_spi_pkg.sv
// Shared definitions for the note SPI link: frame layout and transmitter states,
// used by the transmitter, the note receiver and their benches.
package note_spi_pkg;

    localparam int FRAME_BITS = 24;
    localparam int TUNE_BITS  = 16;
    localparam int VOL_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } tx_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/note_spi_tx_phase_timer.sv
// Loadable down-counter that times every interval of the SPI transmitter FSM.
// Loading N makes expire assert in the N-th cycle after the load edge.
module spi_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/note_spi_tx.sv
// SPI mode-0 master that sends one 24-bit note frame (tuneWord then volume, MSB first)
// with an active-high chipSelect; all outputs are registered.
module note_spi_tx
    import note_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [TUNE_BITS-1:0] tuneWordIn,
    input  logic [VOL_BITS-1:0]  volumeIn,
    output logic                 ready,
    output logic                 chipSelect,
    output logic                 sck,
    output logic                 sdi,
    output logic                 done
);

    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP) + 1);

    tx_state_t              state;
    tx_state_t              state_next;
    logic [FRAME_BITS-1:0]  shift;
    logic [FRAME_BITS-1:0]  shift_next;
    logic [4:0]             bit_cnt;
    logic [4:0]             bit_cnt_next;
    logic                   timer_load;
    logic [CNT_W-1:0]       timer_value;
    logic                   expire;
    logic                   ready_next;
    logic                   cs_next;
    logic                   sck_next;
    logic                   sdi_next;
    logic                   done_next;

    spi_phase_timer #(.W(CNT_W)) phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:              if (valid && ready) state_next = SETUP;
            SETUP:             if (expire) state_next = HIGH;
            HIGH:              if (expire) state_next = (bit_cnt == 5'(FRAME_BITS)) ? HOLD : LOW;
            LOW:               if (expire) state_next = HIGH;
            HOLD:              if (expire) state_next = note_spi_pkg::GAP;
            note_spi_pkg::GAP: if (expire) state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    // Every state change restarts the timer with the length of the interval being entered.
    assign timer_load = (state_next != state);

    always_comb begin
        case (state_next)
            SETUP:             timer_value = CNT_W'(CS_SETUP);
            HIGH, LOW:         timer_value = CNT_W'(CLK_DIV);
            HOLD:              timer_value = CNT_W'(CS_HOLD);
            note_spi_pkg::GAP: timer_value = CNT_W'(GAP);
            default:           timer_value = '0;
        endcase
    end

    always_comb begin
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        if (state == IDLE && state_next == SETUP) begin
            shift_next   = {tuneWordIn, volumeIn};
            bit_cnt_next = '0;
        end else if (state == HIGH && state_next == LOW) begin
            shift_next = shift << 1;
        end
        if (state_next == HIGH && state != HIGH) begin
            bit_cnt_next = bit_cnt + 5'd1;
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        ready_next = (state_next == IDLE);
        cs_next    = state_next inside {SETUP, LOW, HIGH, HOLD};
        sck_next   = (state_next == HIGH);
        sdi_next   = cs_next ? shift_next[FRAME_BITS-1] : 1'b0;
        done_next  = (state == HOLD) && (state_next == note_spi_pkg::GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready      <= 1'b1;
            chipSelect <= 1'b0;
            sck        <= 1'b0;
            sdi        <= 1'b0;
            done       <= 1'b0;
        end else begin
            ready      <= ready_next;
            chipSelect <= cs_next;
            sck        <= sck_next;
            sdi        <= sdi_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_note_spi_tx.sv
// Bench for note_spi_tx: a slow instance (CLK_DIV=2) and a fast one (CLK_DIV=1), both
// compared frame by frame against expectations derived from the frame format and timing rules.
module tb_note_spi_tx;

    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int GAP      = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid0;
    logic        valid1;
    logic [15:0] tuneWordIn;
    logic [7:0]  volumeIn;
    logic        ready0, cs0, sck0, sdi0, done0;
    logic        ready1, cs1, sck1, sdi1, done1;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int acc0[$];

    logic [23:0] rxShift   = '0;
    int          rxCnt     = 0;
    logic        rxPrevSck = 1'b0;
    logic        rxPrevCs  = 1'b0;
    logic [15:0] rxTune    = '0;
    logic [7:0]  rxVol     = '0;

    always #5 clk = ~clk;

    note_spi_tx #(.CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) dutSlow (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid0),
        .tuneWordIn (tuneWordIn),
        .volumeIn   (volumeIn),
        .ready      (ready0),
        .chipSelect (cs0),
        .sck        (sck0),
        .sdi        (sdi0),
        .done       (done0)
    );

    note_spi_tx #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) dutFast (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid1),
        .tuneWordIn (tuneWordIn),
        .volumeIn   (volumeIn),
        .ready      (ready1),
        .chipSelect (cs1),
        .sck        (sck1),
        .sdi        (sdi1),
        .done       (done1)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && valid0 && ready0) acc0.push_back(cyc);
    end

    // Receiver model on the slow link: shift on sck rise, publish only complete frames on cs fall.
    always @(posedge clk) begin
        rxPrevSck <= sck0;
        rxPrevCs  <= cs0;
        if (cs0 === 1'b0) begin
            rxCnt <= 0;
            if (rxPrevCs === 1'b1 && rxCnt == 24) begin
                rxTune <= rxShift[23:8];
                rxVol  <= rxShift[7:0];
            end
        end else if (cs0 === 1'b1 && sck0 === 1'b1 && rxPrevSck === 1'b0) begin
            rxShift <= {rxShift[22:0], sdi0};
            rxCnt   <= rxCnt + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [4:0] sampleDut(input bit fast);
        return fast ? {ready1, cs1, sck1, sdi1, done1} : {ready0, cs0, sck0, sdi0, done0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame (call at a negedge) and checks bits, timing, done and ready recovery.
    task automatic applyStimulus(input bit fast, input logic [15:0] tw, input logic [7:0] vol,
                                 input bit keepValid, input logic [15:0] nextTw,
                                 input logic [7:0] nextVol);
        int          div, csExpect, waitCnt, csHigh, sckHigh, rises, doneCnt;
        int          doneAt, readyAt, sdiBad;
        logic [4:0]  cur, prev;
        logic [23:0] bits;
        bit          doneAtFall;
        div        = fast ? 1 : 2;
        csExpect   = CS_SETUP + 47 * div + CS_HOLD;
        tuneWordIn = tw;
        volumeIn   = vol;
        if (fast) valid1 = 1'b1; else valid0 = 1'b1;
        waitCnt = 0;
        cur = sampleDut(fast);
        while (cur[4] !== 1'b1 && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
            cur = sampleDut(fast);
        end
        checkOutput("accept_wait_bound", 32'(waitCnt >= 300), 0);
        @(negedge clk);
        if (keepValid) begin
            tuneWordIn = nextTw;
            volumeIn   = nextVol;
        end else begin
            valid0     = 1'b0;
            valid1     = 1'b0;
            tuneWordIn = 16'($urandom);
            volumeIn   = 8'($urandom);
        end
        prev = 5'b10000;
        bits = '0;
        rises = 0; csHigh = 0; sckHigh = 0; doneCnt = 0; sdiBad = 0;
        doneAt = -1; readyAt = -1; doneAtFall = 1'b0;
        for (int sample = 0; sample < 400; sample++) begin
            if (sample != 0) @(negedge clk);
            cur = sampleDut(fast);
            if (sample == 0) checkOutput("ready_low_after_accept", 32'(cur[4]), 0);
            if (cur[3]) csHigh++;
            if (cur[2]) sckHigh++;
            if (cur[2] && !prev[2]) begin
                if (rises < 24) bits[23-rises] = cur[1];
                rises++;
            end
            if (cur[3] && prev[3] && cur[1] !== prev[1] && !(prev[2] && !cur[2])) sdiBad++;
            if (cur[0]) begin
                doneCnt++;
                doneAt     = sample;
                doneAtFall = prev[3] && !cur[3];
            end
            if (doneAt >= 0 && cur[4]) readyAt = sample;
            prev = cur;
            if (readyAt >= 0) break;
        end
        checkOutput("frame_bits", 32'(bits), 32'({tw, vol}));
        checkOutput("sck_rises", rises, 24);
        checkOutput("cs_high_cycles", csHigh, csExpect);
        checkOutput("sck_high_cycles", sckHigh, 24 * div);
        checkOutput("done_count", doneCnt, 1);
        checkOutput("done_at_cs_fall", 32'(doneAtFall), 1);
        checkOutput("ready_after_done", readyAt - doneAt, GAP);
        checkOutput("sdi_stable", sdiBad, 0);
    endtask

    initial begin
        logic [15:0] tw;
        logic [7:0]  vol;
        int          n0, waitCnt, rises, doneSeen, csSeen;
        logic        prevSck;
        logic [23:0] lastFrame;

        reset      = 1'b1;
        valid0     = 1'b1;
        valid1     = 1'b1;
        tuneWordIn = 16'hDEAD;
        volumeIn   = 8'hBE;
        repeat (3) @(negedge clk);
        checkOutput("reset_state_slow", 32'({ready0, cs0, sck0, sdi0, done0}), 32'b10000);
        checkOutput("reset_state_fast", 32'({ready1, cs1, sck1, sdi1, done1}), 32'b10000);
        reset  = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        csSeen = 0;
        repeat (4) begin
            @(negedge clk);
            if (cs0 || cs1) csSeen++;
        end
        checkOutput("no_frame_after_reset", csSeen, 0);
        checkOutput("no_accept_during_reset", acc0.size(), 0);

        applyStimulus(1'b0, 16'hA5C3, 8'h7E, 1'b0, '0, '0);
        checkOutput("rx_a5c3", 32'({rxTune, rxVol}), 32'h00A5C37E);

        applyStimulus(1'b0, 16'h0400, 8'h80, 1'b0, '0, '0);
        checkOutput("rx_0400", 32'({rxTune, rxVol}), 32'h00040080);
        applyStimulus(1'b0, 16'hFFFF, 8'h01, 1'b0, '0, '0);
        checkOutput("rx_ffff", 32'({rxTune, rxVol}), 32'h00FFFF01);

        n0 = acc0.size();
        applyStimulus(1'b0, 16'h1111, 8'h22, 1'b1, 16'h3333, 8'h44);
        applyStimulus(1'b0, 16'h3333, 8'h44, 1'b1, 16'h5555, 8'h66);
        applyStimulus(1'b0, 16'h5555, 8'h66, 1'b0, '0, '0);
        checkOutput("b2b_accept_count", acc0.size() - n0, 3);
        if (acc0.size() - n0 == 3) begin
            checkOutput("b2b_spacing_1", acc0[n0+1] - acc0[n0], 1 + (CS_SETUP + 47 * 2 + CS_HOLD) + GAP);
            checkOutput("b2b_spacing_2", acc0[n0+2] - acc0[n0+1], 1 + (CS_SETUP + 47 * 2 + CS_HOLD) + GAP);
        end
        checkOutput("rx_b2b_last", 32'({rxTune, rxVol}), 32'h00555566);
        lastFrame = {rxTune, rxVol};

        tuneWordIn = 16'hCAFE;
        volumeIn   = 8'hF0;
        valid0     = 1'b1;
        @(negedge clk);
        valid0  = 1'b0;
        rises   = 0;
        waitCnt = 0;
        prevSck = sck0;
        while (rises < 10 && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
            if (sck0 && !prevSck) rises++;
            prevSck = sck0;
        end
        checkOutput("abort_rise10_reached", rises, 10);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_outputs", 32'({ready0, cs0, sck0, done0}), 32'b1000);
        reset    = 1'b0;
        doneSeen = 0;
        csSeen   = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) doneSeen++;
            if (cs0) csSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_no_tail", csSeen, 0);
        checkOutput("abort_rx_unchanged", 32'({rxTune, rxVol}), 32'(lastFrame));
        applyStimulus(1'b0, 16'h1234, 8'h56, 1'b0, '0, '0);
        checkOutput("rx_1234", 32'({rxTune, rxVol}), 32'h00123456);

        applyStimulus(1'b1, 16'h8001, 8'h80, 1'b0, '0, '0);

        for (int i = 0; i < 4; i++) begin
            tw  = 16'($urandom);
            vol = 8'($urandom);
            applyStimulus(1'b0, tw, vol, 1'b0, '0, '0);
            checkOutput("rx_random", 32'({rxTune, rxVol}), 32'({tw, vol}));
        end
        for (int i = 0; i < 3; i++) begin
            tw  = 16'($urandom);
            vol = 8'($urandom);
            applyStimulus(1'b1, tw, vol, 1'b0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
